fft_frame_feeder: RTL and testbench

- Input-side framer for the pipelined radix-2 FFT core; the transmitter for the core's `din_en`/`din`/`din_cnt` receive interface.
- Accepts real samples from an upstream source over a valid/ready handshake and buffers them in an on-chip FIFO.
- Emits each 2^NALL-sample frame as one contiguous burst: `out_en` is high for 2^NALL consecutive cycles and `out_cnt` runs 0..2^NALL-1.
- Sits between the ADC/sample source and the FFT core input.

---
 rtl/fft_frame_feeder_pkg.sv | 24 ++
 rtl/fft_frame_feeder_ram.sv | 29 ++
 rtl/fft_frame_feeder.sv | 146 ++++++++++++++
 tb/tb_fft_frame_feeder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_feeder_pkg.sv
// Shared constants and FSM encoding for the FFT input framer.
package fft_frame_feeder_pkg;

  localparam int unsigned NALL_DEFAULT = 9;
  localparam int unsigned FRAME_LEN    = 2 ** NALL_DEFAULT;
  localparam int unsigned FIFO_DEPTH   = 2 ** (NALL_DEFAULT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } feed_state_t;

  // Frame length for an arbitrary log2 size.
  function automatic int unsigned frame_len(input int unsigned nall);
    return 32'd1 << nall;
  endfunction

  // FIFO depth holds two whole frames.
  function automatic int unsigned fifo_depth(input int unsigned nall);
    return 32'd1 << (nall + 1);
  endfunction

endpackage

// File: rtl/fft_frame_feeder_ram.sv
// Simple dual-port sample memory with a registered read port.
module frame_fifo_ram #(
  parameter int width = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [width-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [width-1:0] rd_data
);

  logic [width-1:0] mem [2**AW];

  // Storage write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value between reads and clears on reset.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset)    rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Buffers upstream samples and emits each frame as one contiguous burst.
module fft_frame_feeder
  import fft_frame_feeder_pkg::*;
#(
  parameter int width = 16,
  parameter int NALL  = 9,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  input  logic [width-1:0] in_data,
  output logic             in_ready,
  output logic             out_en,
  output logic [NALL-1:0]  out_cnt,
  output logic [width-1:0] out_data,
  output logic             frame_start,
  output logic [NALL+1:0]  fill
);

  localparam int unsigned PW = NALL + 2;
  localparam int unsigned AW = NALL + 1;
  localparam logic [PW-1:0] FILL_FRAME = PW'(frame_len(NALL));
  localparam logic [PW-1:0] FILL_FULL  = PW'(fifo_depth(NALL));
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  feed_state_t     state, state_n;
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic            wr_en, rd_en, frame_ready;
  logic            en_n, fs_n;
  logic [NALL-1:0] cnt_n;
  logic [GW-1:0]   gap_cnt, gap_n;

  assign fill        = wr_ptr - rd_ptr;
  assign wr_en       = in_valid && in_ready;
  assign frame_ready = fill >= FILL_FRAME;

  // Pointer advance for this cycle's accepted write and issued read.
  always_comb begin
    wr_ptr_n = wr_ptr + PW'(wr_en);
    rd_ptr_n = rd_ptr + PW'(rd_en);
  end

  // Pointers; in_ready is registered from the post-edge fill so a write
  // can never land on a full FIFO.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      in_ready <= (wr_ptr_n - rd_ptr_n) != FILL_FULL;
    end
  end

  // Next state and frame controls; leaving GAP re-applies the IDLE start
  // test on the same edge so exactly GAP idle cycles separate frames.
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    en_n    = 1'b0;
    fs_n    = 1'b0;
    cnt_n   = '0;
    gap_n   = '0;
    case (state)
      ST_IDLE: begin
        if (frame_ready) begin
          state_n = ST_SEND;
          rd_en   = 1'b1;
          en_n    = 1'b1;
          fs_n    = 1'b1;
        end
      end
      ST_SEND: begin
        if (out_cnt != '1) begin
          rd_en = 1'b1;
          en_n  = 1'b1;
          cnt_n = out_cnt + NALL'(1);
        end else if (GAP > 0) begin
          state_n = ST_GAP;
        end else if (frame_ready) begin
          rd_en = 1'b1;
          en_n  = 1'b1;
          fs_n  = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt != GAP_LAST) begin
          gap_n = gap_cnt + GW'(1);
        end else if (frame_ready) begin
          state_n = ST_SEND;
          rd_en   = 1'b1;
          en_n    = 1'b1;
          fs_n    = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and gap counter registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_n;
    end
  end

  // Registered frame outputs aligned with the memory read register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      out_en      <= 1'b0;
      out_cnt     <= '0;
      frame_start <= 1'b0;
    end else begin
      out_en      <= en_n;
      out_cnt     <= cnt_n;
      frame_start <= fs_n;
    end
  end

  frame_fifo_ram #(
    .width (width),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .areset  (areset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder: NALL=3 with GAP of 0, 2 and 12.
module tb_fft_frame_feeder;

  localparam int W = 16;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic          iv   [3];
  logic [W-1:0]  idat [3];
  logic          ir   [3];
  logic          oe   [3];
  logic [N-1:0]  oc   [3];
  logic [W-1:0]  od   [3];
  logic          ofs  [3];
  logic [N+1:0]  fl   [3];

  fft_frame_feeder #(.width(W), .NALL(N), .GAP(0)) u_a (
    .clk(clk), .areset(areset), .in_valid(iv[0]), .in_data(idat[0]),
    .in_ready(ir[0]), .out_en(oe[0]), .out_cnt(oc[0]), .out_data(od[0]),
    .frame_start(ofs[0]), .fill(fl[0]));

  fft_frame_feeder #(.width(W), .NALL(N), .GAP(2)) u_b (
    .clk(clk), .areset(areset), .in_valid(iv[1]), .in_data(idat[1]),
    .in_ready(ir[1]), .out_en(oe[1]), .out_cnt(oc[1]), .out_data(od[1]),
    .frame_start(ofs[1]), .fill(fl[1]));

  fft_frame_feeder #(.width(W), .NALL(N), .GAP(12)) u_c (
    .clk(clk), .areset(areset), .in_valid(iv[2]), .in_data(idat[2]),
    .in_ready(ir[2]), .out_en(oe[2]), .out_cnt(oc[2]), .out_data(od[2]),
    .frame_start(ofs[2]), .fill(fl[2]));

  typedef struct {
    bit v;   int d;
    bit en;  int cnt; int dat; bit fs; int fil;
  } vec_t;

  vec_t tbl [17];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input int c, input string nm, input bit en,
                           input int cnt, input int dat, input bit fs);
    chk({nm, ".en"}, int'(oe[c]), int'(en));
    chk({nm, ".cnt"}, int'(oc[c]), en ? cnt : 0);
    chk({nm, ".fs"}, int'(ofs[c]), int'(en && fs));
    if (en) chk({nm, ".data"}, int'($signed(od[c])), dat);
  endtask

  function automatic int sval(input int k);
    case (k)
      3:       return -32768;
      5:       return -1;
      10:      return 32767;
      default: return k * 7 - 50;
    endcase
  endfunction

  // Single-frame table run on u_a, starting empty and idle with out_data=0.
  task automatic run_table(input string tag);
    for (int r = 0; r < 17; r++) begin
      iv[0]   = tbl[r].v;
      idat[0] = W'(tbl[r].d);
      tick();
      chk($sformatf("%s[%0d].en", tag, r), int'(oe[0]), int'(tbl[r].en));
      chk($sformatf("%s[%0d].cnt", tag, r), int'(oc[0]), tbl[r].cnt);
      chk($sformatf("%s[%0d].data", tag, r), int'($signed(od[0])), tbl[r].dat);
      chk($sformatf("%s[%0d].fs", tag, r), int'(ofs[0]), int'(tbl[r].fs));
      chk($sformatf("%s[%0d].fill", tag, r), int'(fl[0]), tbl[r].fil);
      chk($sformatf("%s[%0d].rdy", tag, r), int'(ir[0]), 1);
    end
    iv[0] = 1'b0;
  endtask

  task automatic release_reset(input string tag);
    for (int c = 0; c < 3; c++) iv[c] = 1'b0;
    @(negedge clk);
    areset = 1'b1;
    #1;
    chk({tag, ".rdy_before_edge"}, int'(ir[0]), 0);
    tick();
    chk({tag, ".rdy_after_edge"}, int'(ir[0]), 1);
    chk({tag, ".fill_after_edge"}, int'(fl[0]), 0);
  endtask

  initial begin
    // Feed rows: samples 0..7, then frame out one edge after the last write.
    for (int k = 0; k < 8; k++) tbl[k] = '{1'b1, k, 1'b0, 0, 0, 1'b0, k + 1};
    for (int j = 0; j < 8; j++) tbl[8 + j] = '{1'b0, 0, 1'b1, j, j, (j == 0), 7 - j};
    tbl[16] = '{1'b0, 0, 1'b0, 0, 7, 1'b0, 0};

    // Reset with in_valid high must not buffer anything.
    areset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      iv[c]   = 1'b1;
      idat[c] = 16'd123;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst.en", int'(oe[0]), 0);
    chk("rst.cnt", int'(oc[0]), 0);
    chk("rst.data", int'(od[0]), 0);
    chk("rst.fs", int'(ofs[0]), 0);
    chk("rst.rdy", int'(ir[0]), 0);
    chk("rst.fill", int'(fl[0]), 0);
    chk("rst.fill_c", int'(fl[2]), 0);
    release_reset("rel1");

    run_table("single");

    // Back-to-back: 24 samples stream into three contiguous frames.
    for (int r = 0; r < 34; r++) begin
      iv[0]   = (r < 24);
      idat[0] = W'(100 + r);
      tick();
      if (r >= 8 && r < 32)
        check_out(0, $sformatf("b2b[%0d]", r), 1'b1, (r - 8) % 8, 100 + r - 8, ((r - 8) % 8) == 0);
      else
        check_out(0, $sformatf("b2b[%0d]", r), 1'b0, 0, 0, 1'b0);
    end
    iv[0] = 1'b0;
    chk("b2b.fill_end", int'(fl[0]), 0);

    // GAP=2: exactly two idle cycles between the frames.
    for (int r = 0; r < 28; r++) begin
      iv[1]   = (r < 16);
      idat[1] = W'(200 + r);
      tick();
      if (r >= 8 && r < 16)
        check_out(1, $sformatf("gap[%0d]", r), 1'b1, r - 8, 200 + r - 8, r == 8);
      else if (r >= 18 && r < 26)
        check_out(1, $sformatf("gap[%0d]", r), 1'b1, r - 18, 208 + r - 18, r == 18);
      else
        check_out(1, $sformatf("gap[%0d]", r), 1'b0, 0, 0, 1'b0);
    end
    iv[1] = 1'b0;

    // GAP=12 lets the FIFO fill to 16 and exercise backpressure.
    begin
      int  k, nout;
      bit  rdy_prev, rdy_exp;
      k = 0;
      nout = 0;
      rdy_prev = 1'b1;
      for (int r = 0; r < 74; r++) begin
        iv[2]   = (r < 34);
        idat[2] = W'(sval(k));
        tick();
        if (r < 34) begin
          if (rdy_prev) k++;
          rdy_exp = (r < 23) || (r >= 28);
          chk($sformatf("full.rdy[%0d]", r), int'(ir[2]), int'(rdy_exp));
          rdy_prev = rdy_exp;
        end
        if (oe[2]) begin
          chk($sformatf("full.data[%0d]", nout), int'($signed(od[2])), sval(nout));
          chk($sformatf("full.cnt[%0d]", nout), int'(oc[2]), nout % 8);
          nout++;
        end
      end
      iv[2] = 1'b0;
      chk("full.nout", nout, 24);
      chk("full.fill_end", int'(fl[2]), 5);
    end

    // Mid-frame reset aborts the frame and drops the buffered samples.
    begin
      bit found;
      found = 1'b0;
      for (int r = 0; r < 8; r++) begin
        iv[0]   = 1'b1;
        idat[0] = W'(40 + r);
        tick();
      end
      iv[0] = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
        tick();
        if (oe[0] && oc[0] == 3'd4) found = 1'b1;
      end
      chk("mid.reached_cnt4", int'(found), 1);
      areset = 1'b0;
      #1;
      chk("mid.en", int'(oe[0]), 0);
      chk("mid.cnt", int'(oc[0]), 0);
      chk("mid.fill", int'(fl[0]), 0);
      chk("mid.rdy", int'(ir[0]), 0);
      release_reset("rel2");
      run_table("fresh");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
